fifo_wr_arbiter: RTL and testbench

//  Shares the write port of one SyncFIFO among NUM_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
// The state encoding and the owner/beat-counter widths live here.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the per-grant beat counter; never narrower than one bit.
  function automatic int cnt_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: the first set req bit scanning last+1, last+2, ...
// with explicit wrap modulo NUM_REQ. Purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // cand[gi] is the requester at scan position gi, i.e. last+1+gi mod NUM_REQ.
  // last < NUM_REQ, so the sum stays below 2*NUM_REQ and one subtraction wraps it.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum         = {1'b0, last} + (IDX_W+1)'(gi + 1);
    assign cand[gi]    = (sum >= (IDX_W+1)'(NUM_REQ))
                         ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                         : IDX_W'(sum);
    assign hit[gi]     = req[cand[gi]];
  end

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        valid = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one SyncFIFO write port among
// NUM_REQ producers, with per-beat backpressure from the FIFO full flag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_din,
  output logic                      busy
);

  localparam int OW = idx_w(NUM_REQ);
  localparam int CW = cnt_w(MAX_BURST);
  localparam logic [CW-1:0]      LAST_BEAT  = CW'(MAX_BURST - 1);
  localparam logic [OW-1:0]      LAST_REQ   = OW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0  = NUM_REQ'(1);

  arb_state_e         state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_owner_q, last_owner_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic               pick_valid;
  logic [OW-1:0]      pick_idx;
  logic               accept;
  logic [DATA_W-1:0]  slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OW)
  ) u_rr_pick (
    .req   (req),
    .last  (last_owner_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // A beat is taken only from the owner, only when the FIFO has room,
  // and never in a reset cycle.
  assign accept = (state_q == BURST) & req[owner_q] & ~fifo_full & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_REQ;
      beat_cnt_q   <= '0;
      gnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      gnt_q        <= gnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    gnt_d        = gnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          owner_d    = pick_idx;
          gnt_d      = ONE_HOT_0 << pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // A stalled owner (req high, FIFO full) falls through with everything held.
        if (!req[owner_q] ||
            (accept && (req_last[owner_q] || beat_cnt_q == LAST_BEAT))) begin
          state_d      = IDLE;
          gnt_d        = '0;
          last_owner_d = owner_q;
          beat_cnt_d   = '0;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_wr_en = accept;
    ack        = accept ? gnt_q : '0;
    busy       = (state_q == BURST) & ~rst;
    fifo_din   = rst ? '0 : slice[owner_q];
  end

  assign gnt = gnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a cycle table for the basic flows plus
// hand-written sequences for max-burst rotation, FIFO stalls and mid-burst reset.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     ack;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_din;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] wr_log [$];

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .gnt        (gnt),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] last;
    logic          full;
    logic [NR-1:0] gnt;
    logic [NR-1:0] ack;
    logic          we;
    logic          busy;
    logic [DW-1:0] din;
  } vec_t;

  vec_t vt [25];

  function automatic vec_t mk(logic r, logic [NR-1:0] rq, logic [NR-1:0] ls, logic fl,
                              logic [NR-1:0] g, logic [NR-1:0] a, logic w, logic b,
                              logic [DW-1:0] d);
    vec_t v;
    v.rst = r; v.req = rq; v.last = ls; v.full = fl;
    v.gnt = g; v.ack = a; v.we = w; v.busy = b; v.din = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: logs every FIFO write and checks none happens while full.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      wr_log.push_back(fifo_din);
      checks++;
      if (fifo_full !== 1'b0) begin
        errors++;
        $display("FAIL wr_while_full act=%0b exp=0 t=%0t", fifo_full, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cyc;
    // Table: data slices fixed at r0=11 r1=22 r2=33 r3=44.
    vt[0]  = mk(1, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[1]  = mk(0, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[2]  = mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1, 8'h11);
    vt[3]  = mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 1, 8'h11);
    vt[4]  = mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 1, 1, 8'h11);
    vt[5]  = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[6]  = mk(1, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[7]  = mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[8]  = mk(0, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0001, 1, 1, 8'h11);
    vt[9]  = mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[10] = mk(0, 4'b1111, 4'b1111, 0, 4'b0010, 4'b0010, 1, 1, 8'h22);
    vt[11] = mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[12] = mk(0, 4'b1111, 4'b1111, 0, 4'b0100, 4'b0100, 1, 1, 8'h33);
    vt[13] = mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[14] = mk(0, 4'b1111, 4'b1111, 0, 4'b1000, 4'b1000, 1, 1, 8'h44);
    vt[15] = mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[16] = mk(0, 4'b1111, 4'b1111, 0, 4'b0001, 4'b0001, 1, 1, 8'h11);
    vt[17] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[18] = mk(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[19] = mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1, 8'h22);
    vt[20] = mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1, 8'h22);
    vt[21] = mk(0, 4'b0100, 4'b0000, 0, 4'b0010, 4'b0000, 0, 1, 8'h00);
    vt[22] = mk(0, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);
    vt[23] = mk(0, 4'b0100, 4'b0100, 0, 4'b0100, 4'b0100, 1, 1, 8'h33);
    vt[24] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00);

    rst = 1'b1; req = '0; req_last = '0; fifo_full = 1'b0;
    req_data = 32'h44332211;
    #1;
    tick();
    tick();

    for (int i = 0; i < 25; i++) begin
      rst = vt[i].rst; req = vt[i].req; req_last = vt[i].last; fifo_full = vt[i].full;
      @(negedge clk);
      $display("vec %0d rst=%0b req=%b gnt=%b ack=%b we=%0b busy=%0b din=%0h",
               i, rst, req, gnt, ack, fifo_wr_en, busy, fifo_din);
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vt[i].ack));
      chk($sformatf("vec%0d_we", i), 32'(fifo_wr_en), 32'(vt[i].we));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      if (vt[i].we || vt[i].rst)
        chk($sformatf("vec%0d_din", i), 32'(fifo_din), 32'(vt[i].din));
      tick();
    end

    // Max-burst rotation: v=0 only r2 requests, v=1 r3 is also pending.
    for (int v = 0; v < 2; v++) begin
      rst = 1'b1; req = '0; req_last = '0; fifo_full = 1'b0;
      tick();
      rst = 1'b0;
      req = (v == 1) ? 4'b1100 : 4'b0100;
      req_data[2*DW +: DW] = 8'h80;
      wr_log.delete();
      tick();
      n = 0; cyc = 0;
      while (gnt === 4'b0100 && cyc < 40) begin
        req_data[2*DW +: DW] = DW'(8'h80 + n);
        @(negedge clk);
        if (ack[2] === 1'b1) n++;
        tick();
        cyc++;
      end
      $display("maxburst v=%0d acks=%0d cycles=%0d", v, n, cyc);
      chk($sformatf("maxb%0d_acks", v), 32'(n), 32'(MB));
      chk($sformatf("maxb%0d_bubble_busy", v), 32'(busy), 32'(0));
      chk($sformatf("maxb%0d_bubble_gnt", v), 32'(gnt), 32'(0));
      chk($sformatf("maxb%0d_logsize", v), 32'(wr_log.size()), 32'(MB));
      for (int k = 0; k < MB && k < wr_log.size(); k++)
        chk($sformatf("maxb%0d_word%0d", v, k), 32'(wr_log[k]), 32'(8'h80 + k));
      tick();
      chk($sformatf("maxb%0d_next_gnt", v), 32'(gnt), (v == 1) ? 32'h8 : 32'h4);
      req = '0;
      tick();
      tick();
    end

    // FIFO full for 5 cycles mid-burst: owner and data word held.
    rst = 1'b1; req = '0; req_last = '0; fifo_full = 1'b0;
    tick();
    rst = 1'b0; req = 4'b0001; req_data[0 +: DW] = 8'hA0;
    wr_log.delete();
    tick();
    @(negedge clk);
    chk("stall_first_ack", 32'(ack), 32'h1);
    tick();
    req_data[0 +: DW] = 8'hA1; fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      $display("stall cyc=%0d gnt=%b ack=%b we=%0b busy=%0b din=%0h",
               c, gnt, ack, fifo_wr_en, busy, fifo_din);
      chk($sformatf("stall%0d_we", c), 32'(fifo_wr_en), 32'(0));
      chk($sformatf("stall%0d_ack", c), 32'(ack), 32'(0));
      chk($sformatf("stall%0d_gnt", c), 32'(gnt), 32'h1);
      chk($sformatf("stall%0d_busy", c), 32'(busy), 32'(1));
      tick();
    end
    fifo_full = 1'b0; req_last = 4'b0001;
    @(negedge clk);
    chk("resume_we", 32'(fifo_wr_en), 32'(1));
    chk("resume_din", 32'(fifo_din), 32'hA1);
    chk("resume_ack", 32'(ack), 32'h1);
    tick();
    req = '0; req_last = '0;
    chk("stall_log_size", 32'(wr_log.size()), 32'(2));
    if (wr_log.size() == 2) begin
      chk("stall_log0", 32'(wr_log[0]), 32'hA0);
      chk("stall_log1", 32'(wr_log[1]), 32'hA1);
    end
    chk("stall_end_gnt", 32'(gnt), 32'(0));

    // Reset during a stalled burst, then arbitration restarts at requester 0.
    tick();
    req = 4'b0010; fifo_full = 1'b1;
    tick();
    chk("rststall_gnt", 32'(gnt), 32'h2);
    tick();
    rst = 1'b1;
    @(negedge clk);
    $display("rst-in-stall we=%0b ack=%b busy=%0b din=%0h", fifo_wr_en, ack, busy, fifo_din);
    chk("rststall_we", 32'(fifo_wr_en), 32'(0));
    chk("rststall_ack", 32'(ack), 32'(0));
    chk("rststall_busy", 32'(busy), 32'(0));
    chk("rststall_din", 32'(fifo_din), 32'(0));
    tick();
    rst = 1'b0; req = 4'b1111; fifo_full = 1'b0; req_last = 4'b1111;
    @(negedge clk);
    chk("postrst_gnt", 32'(gnt), 32'(0));
    chk("postrst_busy", 32'(busy), 32'(0));
    tick();
    @(negedge clk);
    chk("postrst_first_gnt", 32'(gnt), 32'h1);
    chk("postrst_first_din", 32'(fifo_din), 32'h11 ^ 32'(req_data[7:0]) ^ 32'h11);
    tick();
    req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
